// File: rtl/challengeqsys_pixbuf.sv
// challengeqsys_pixbuf: dual-port pixel memory with Avalon slave, streaming scan engine and fill engine
module challengeqsys_pixbuf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15,
  parameter INIT_FILE = "challengeqsys_pixbuf.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_waitrequest,
  input  logic                    scan_start,
  input  logic [ADDR_WIDTH-1:0]   scan_base,
  input  logic [ADDR_WIDTH:0]     scan_len,
  output logic                    scan_busy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop,
  input  logic                    fill_start,
  input  logic [DATA_WIDTH-1:0]   fill_value,
  output logic                    fill_busy
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] fill_addr, rd_addr, a_addr;
  logic [DATA_WIDTH-1:0] fill_val, rd_data, a_wdata;
  logic [DATA_WIDTH/8-1:0] a_be;
  logic [ADDR_WIDTH:0] rd_left;
  logic [1:0] cnt;
  logic [1:0][DATA_WIDTH-1:0] f_data;
  logic [1:0] f_sop, f_eop;
  logic a_we, fill_go, scan_go, issue, pop, last, first, rd_valid, rd_sop, rd_eop, wp, rp;
  assign scan_busy = state != IDLE;
  assign s1_waitrequest = fill_busy;
  assign out_valid = cnt != 2'd0;
  assign out_data = f_data[rp];
  assign out_sop = out_valid && f_sop[rp];
  assign out_eop = out_valid && f_eop[rp];
  always_comb begin
    fill_go = fill_start && !fill_busy && !scan_busy;
    scan_go = scan_start && scan_len != '0 && state == IDLE && !fill_busy && !fill_go;
    pop = out_valid && out_ready;
    last = rd_left == (ADDR_WIDTH+1)'(1);
    // counting the word leaving this cycle keeps the 2-entry FIFO at full rate
    issue = state == RUN && (cnt + 2'(rd_valid) - 2'(pop)) < 2'd2;
    a_we = fill_busy || (clken && s1_chipselect && s1_write);
    a_addr = fill_busy ? fill_addr : s1_address;
    a_wdata = fill_busy ? fill_val : s1_writedata;
    a_be = fill_busy ? '1 : s1_byteenable;
    state_n = state == IDLE ? (scan_go ? RUN : IDLE) :
              state == RUN  ? (issue && last ? DRAIN : RUN) :
                              (pop && out_eop ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++)
      if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    rd_data <= mem[rd_addr];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_readdata <= '0;
      fill_busy <= 1'b0;
      fill_addr <= '0;
      fill_val <= '0;
      rd_addr <= '0;
      rd_left <= '0;
      first <= 1'b0;
      rd_valid <= 1'b0;
      rd_sop <= 1'b0;
      rd_eop <= 1'b0;
      f_data <= '0;
      f_sop <= '0;
      f_eop <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (clken) s1_readdata <= mem[s1_address];
      if (fill_go) begin
        fill_busy <= 1'b1;
        fill_addr <= '0;
        fill_val <= fill_value;
      end else if (fill_busy) begin
        fill_addr <= fill_addr + 1'b1;
        if (&fill_addr) fill_busy <= 1'b0;
      end
      if (scan_go) begin
        rd_addr <= scan_base;
        rd_left <= scan_len;
        first <= 1'b1;
      end else if (issue) begin
        rd_addr <= rd_addr + 1'b1;
        rd_left <= rd_left - 1'b1;
        first <= 1'b0;
      end
      rd_valid <= issue;
      rd_sop <= first;
      rd_eop <= last;
      if (rd_valid) begin
        f_data[wp] <= rd_data;
        f_sop[wp] <= rd_sop;
        f_eop[wp] <= rd_eop;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(rd_valid) - 2'(pop);
    end
  end
endmodule
